pipelined_cache_miss_ctrl: RTL and testbench
============================================

// Module: pipelined_cache_miss_ctrl
// PURPOSE
//  Miss-handling stage directly downstream of the cache pipeline stage registers; consumes the
//  registered hit/dirty/lru/address of the stage-2 request. On a miss it stalls the pipeline,
//  writes back a dirty victim, fills the line from physical memory and installs it in the array.
//  It then replays the request so that it hits. Cache geometry: 2-way, 8 sets, 256-bit lines.
// PARAMETERS
//  TAG_W    24   tag width = address[31:8]
//  SET_W     3   set index width = address[7:5]
//  LINE_W  256   cache line width in bits
// PORTS
//  clk             in   1    clock
//  rst             in   1    synchronous, active-high reset
//  req_valid_i     in   1    stage-2 holds a valid CPU read/write request
//  hit_i           in   1    registered hit for the stage-2 request
//  dirty_i         in   1    registered dirty bit of the LRU (victim) way
//  lru_i           in   1    registered LRU way; this way is the victim
//  address_i       in   32   registered CPU address
//  victim_tag_i    in   24   tag stored in the victim way
//  victim_data_i   in   256  line data of the victim way
//  pmem_resp_i     in   1    physical memory has completed the current read/write
//  pmem_rdata_i    in   256  fill data; valid when pmem_resp_i is high in FILL
//  pmem_read_o     out  1    memory read strobe
//  pmem_write_o    out  1    memory write strobe
//  pmem_address_o  out  32   line-aligned memory address
//  pmem_wdata_o    out  256  writeback data
//  stall_o         out  1    freezes the stage registers and the CPU
//  fill_valid_o    out  1    write fill_data_o into the array this cycle; line is valid and clean
//  fill_way_o      out  1    way to install into
//  fill_set_o      out  3    set to install into
//  fill_tag_o      out  24   tag to install
//  fill_data_o     out  256  line to install
//  miss_count_o    out  32   saturating count of misses
//  wb_count_o      out  32   saturating count of dirty writebacks
// BEHAVIOUR
//  Reset: state=IDLE. All outputs are 0, including both counters and all latched data.
//  States: IDLE, WRITEBACK, FILL, INSTALL, REPLAY.
//  IDLE
//   - A miss is req_valid_i & ~hit_i.
//   - On a miss: stall_o=1 combinationally in the same cycle.
//   - On a miss, latch the following: address_i[31:5], lru_i as victim way, victim_tag_i, victim_data_i.
//   - On a miss: miss_count++. Next state is WRITEBACK if dirty_i, else FILL.
//   - A hit, or req_valid_i=0, produces no action and stall_o=0.
//  WRITEBACK
//   - Outputs: pmem_write_o=1, pmem_address_o={victim_tag,set,5'b0}, pmem_wdata_o=latched victim data.
//   - Outputs are held stable until pmem_resp_i. Then wb_count++ and go to FILL.
//  FILL
//   - Outputs: pmem_read_o=1, pmem_address_o={req_tag,set,5'b0}.
//   - On pmem_resp_i: latch pmem_rdata_i and go to INSTALL.
//  INSTALL
//   - fill_valid_o=1 for exactly one cycle, with latched way/set/tag/data. Go to REPLAY.
//  REPLAY
//   - stall_o=1 for one cycle so the stage re-reads the array and hits. Go to IDLE.
//  stall_o is 1 in every state except IDLE; in IDLE it is as described above.
//  pmem_read_o and pmem_write_o are never asserted together and are 0 outside FILL/WRITEBACK.
//  pmem_resp_i outside WRITEBACK/FILL is ignored.
//  req_valid_i and hit_i are ignored outside IDLE; the upstream stage is frozen by stall_o.
//  Latency: let L = cycles from strobe assertion to pmem_resp_i, inclusive.
//   - Clean miss: stall_o is high for 1+L+1+1 cycles.
//   - Dirty miss: stall_o is high for 1+Lw+Lr+1+1 cycles.
//  Counters saturate at 32'hFFFF_FFFF with no wrap; both increment in the stated cycle only.
//  rst mid-operation:
//   - Return to IDLE next edge and deassert the strobes.
//   - The in-flight request is dropped and nothing is installed.
//   - Counters clear.
//  Back-to-back misses:
//   - The REPLAY->IDLE cycle samples a fresh stage-2 request.
//   - A miss there restarts immediately with no idle gap.
// STRUCTURE
//  Shared package (cache_types): TAG_W/SET_W/LINE_W constants.
//  Shared package (cache_types): miss_state_t enum {IDLE,WRITEBACK,FILL,INSTALL,REPLAY}.
//  Sub-module sat_counter #(W=32) (inc, clr -> count), instantiated twice for the perf counters.
//  Single always_ff for state and latches; single always_comb for next-state and outputs.
// TESTING
//  1. Hit: req_valid=1, hit=1 -> stall_o=0; no pmem strobes; miss_count stays 0.
//  2. Clean miss: addr=32'h0000_1240, dirty=0, lru=1; memory resp after 3 cycles ->
//     pmem_read_o addr 32'h0000_1240; fill_valid_o one cycle with way=1, set=2, tag=24'h000012;
//     stall_o high for 6 cycles total.
//  3. Dirty miss: victim_tag=24'hABCDEF, set=5 -> pmem_write_o addr 32'hABCD_EFA0 with victim data,
//     then read; wb_count=1.
//  4. rst asserted in FILL -> next cycle IDLE; pmem_read_o=0; fill_valid_o never asserts; counters=0.
//  5. Spurious pmem_resp_i in IDLE and INSTALL -> no state change.
//     Miss immediately after REPLAY restarts without an idle cycle.
//  6. Force miss_count to 32'hFFFF_FFFF, then one more miss -> value holds.

Source files
------------

// File: rtl/pipelined_cache_miss_ctrl_pkg.sv
// Shared types and constants for the cache miss-handling slice.
// Geometry: 2-way, 8 sets, 256-bit lines, 32-bit byte addresses.
//   address[31:8] tag | address[7:5] set | address[4:0] byte offset
package pipelined_cache_miss_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned TAG_W  = 24;
    localparam int unsigned SET_W  = 3;
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned LINE_W = 256;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        FILL,
        INSTALL,
        REPLAY
    } miss_state_t;

    // Line-aligned memory address for a given tag/set pair.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [SET_W-1:0] set);
        return {tag, set, {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/pipelined_cache_miss_ctrl_if.sv
// Bus bundle between the cache pipeline / physical memory and the miss controller.
// Ports (by modport):
//   slave  (miss controller): consumes stage-2 request info and pmem response,
//                             drives pmem strobes, stall, array fill and perf counters
//   master (environment):     the opposite directions
interface pipelined_cache_miss_ctrl_if;
    import pipelined_cache_miss_ctrl_pkg::*;

    // stage-2 request side
    logic                req_valid_i;
    logic                hit_i;
    logic                dirty_i;
    logic                lru_i;
    logic [ADDR_W-1:0]   address_i;
    logic [TAG_W-1:0]    victim_tag_i;
    logic [LINE_W-1:0]   victim_data_i;

    // physical memory side
    logic                pmem_resp_i;
    logic [LINE_W-1:0]   pmem_rdata_i;
    logic                pmem_read_o;
    logic                pmem_write_o;
    logic [ADDR_W-1:0]   pmem_address_o;
    logic [LINE_W-1:0]   pmem_wdata_o;

    // pipeline control and array install
    logic                stall_o;
    logic                fill_valid_o;
    logic                fill_way_o;
    logic [SET_W-1:0]    fill_set_o;
    logic [TAG_W-1:0]    fill_tag_o;
    logic [LINE_W-1:0]   fill_data_o;

    // performance counters
    logic [31:0]         miss_count_o;
    logic [31:0]         wb_count_o;

    modport slave (
        input  req_valid_i, hit_i, dirty_i, lru_i, address_i,
               victim_tag_i, victim_data_i, pmem_resp_i, pmem_rdata_i,
        output pmem_read_o, pmem_write_o, pmem_address_o, pmem_wdata_o,
               stall_o, fill_valid_o, fill_way_o, fill_set_o, fill_tag_o,
               fill_data_o, miss_count_o, wb_count_o
    );

    modport master (
        output req_valid_i, hit_i, dirty_i, lru_i, address_i,
               victim_tag_i, victim_data_i, pmem_resp_i, pmem_rdata_i,
        input  pmem_read_o, pmem_write_o, pmem_address_o, pmem_wdata_o,
               stall_o, fill_valid_o, fill_way_o, fill_set_o, fill_tag_o,
               fill_data_o, miss_count_o, wb_count_o
    );

endinterface

// File: rtl/pipelined_cache_miss_ctrl_sat_counter.sv
// Saturating up-counter used for the miss-controller performance counters.
// Ports:
//   clk   in   clock
//   clr   in   synchronous clear (takes priority over inc)
//   inc   in   increment request for this cycle
//   count out  current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // No assignment when saturated or idle: the register simply holds.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipelined_cache_miss_ctrl.sv
// Miss-handling stage behind the cache pipeline stage-2 registers.
// On a miss it stalls the pipeline, writes back a dirty victim, fills the
// line from physical memory, installs it in the array, then holds stall for
// one replay cycle so the frozen request re-reads the array and hits.
// Ports:
//   clk  in  clock
//   rst  in  synchronous, active-high reset
//   bus  slave modport of pipelined_cache_miss_ctrl_if (request info, pmem
//        handshake, stall, array fill, perf counters)
module pipelined_cache_miss_ctrl (
    input  logic                         clk,
    input  logic                         rst,
    pipelined_cache_miss_ctrl_if.slave   bus
);
    import pipelined_cache_miss_ctrl_pkg::*;

    miss_state_t        state, next_state;

    logic [TAG_W-1:0]   req_tag;
    logic [SET_W-1:0]   req_set;
    logic               victim_way;
    logic [TAG_W-1:0]   victim_tag;
    logic [LINE_W-1:0]  victim_data;
    logic [LINE_W-1:0]  fill_data;

    logic               miss;
    logic               miss_inc;
    logic               wb_inc;
    logic [31:0]        miss_count;
    logic [31:0]        wb_count;
    logic               unused_offset;

    assign miss          = bus.req_valid_i & ~bus.hit_i;
    assign miss_inc      = (state == IDLE) & miss;
    assign wb_inc        = (state == WRITEBACK) & bus.pmem_resp_i;
    assign unused_offset = ^bus.address_i[OFF_W-1:0];

    // State register plus the request/victim/fill latches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_tag     <= '0;
            req_set     <= '0;
            victim_way  <= 1'b0;
            victim_tag  <= '0;
            victim_data <= '0;
            fill_data   <= '0;
        end else begin
            state <= next_state;
            if (miss_inc) begin
                req_tag     <= bus.address_i[ADDR_W-1 -: TAG_W];
                req_set     <= bus.address_i[OFF_W +: SET_W];
                victim_way  <= bus.lru_i;
                victim_tag  <= bus.victim_tag_i;
                victim_data <= bus.victim_data_i;
            end
            if ((state == FILL) && bus.pmem_resp_i) begin
                fill_data <= bus.pmem_rdata_i;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (miss) begin
                    next_state = bus.dirty_i ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                if (bus.pmem_resp_i) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (bus.pmem_resp_i) begin
                    next_state = INSTALL;
                end
            end
            INSTALL: next_state = REPLAY;
            REPLAY:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic. Install fields always reflect the latches; they are only
    // meaningful while fill_valid_o is high.
    always_comb begin
        bus.stall_o        = 1'b0;
        bus.pmem_read_o    = 1'b0;
        bus.pmem_write_o   = 1'b0;
        bus.pmem_address_o = '0;
        bus.pmem_wdata_o   = '0;
        bus.fill_valid_o   = 1'b0;
        bus.fill_way_o     = victim_way;
        bus.fill_set_o     = req_set;
        bus.fill_tag_o     = req_tag;
        bus.fill_data_o    = fill_data;
        case (state)
            IDLE: begin
                bus.stall_o = miss;
            end
            WRITEBACK: begin
                bus.stall_o        = 1'b1;
                bus.pmem_write_o   = 1'b1;
                bus.pmem_address_o = line_addr(victim_tag, req_set);
                bus.pmem_wdata_o   = victim_data;
            end
            FILL: begin
                bus.stall_o        = 1'b1;
                bus.pmem_read_o    = 1'b1;
                bus.pmem_address_o = line_addr(req_tag, req_set);
            end
            INSTALL: begin
                bus.stall_o      = 1'b1;
                bus.fill_valid_o = 1'b1;
            end
            REPLAY: begin
                bus.stall_o = 1'b1;
            end
            default: begin
                bus.stall_o = 1'b0;
            end
        endcase
    end

    sat_counter #(.W(32)) u_miss_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

    sat_counter #(.W(32)) u_wb_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (wb_inc),
        .count (wb_count)
    );

    assign bus.miss_count_o = miss_count;
    assign bus.wb_count_o   = wb_count;

endmodule

// File: tb/tb_pipelined_cache_miss_ctrl.sv
// Self-checking bench for pipelined_cache_miss_ctrl: a cycle-by-cycle vector
// table for hit / clean miss / dirty miss, plus hand-written sequences for
// mid-operation reset, spurious responses, back-to-back misses and counter
// saturation.
module tb_pipelined_cache_miss_ctrl;

    logic clk;
    logic rst;

    pipelined_cache_miss_ctrl_if bus();

    pipelined_cache_miss_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] VDATA = {8{32'hDEAD_BEEF}} ^ 256'h0123_4567_89AB_CDEF;
    localparam logic [255:0] RDATA = {8{32'hC0FF_EE00}} ^ 256'h0F0F_1234;

    int tests;
    int failed;

    typedef struct {
        logic        rv, hit, dirty, lru, resp;
        logic [31:0] addr;
        logic [23:0] vtag;
        logic        stall, rd, wr, fv, fway;
        logic [31:0] paddr;
        logic [2:0]  fset;
        logic [23:0] ftag;
        logic [31:0] mc, wc;
    } vec_t;

    vec_t vecs[17];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rv, input logic hit, input logic dirty, input logic lru,
                          input logic [31:0] addr, input logic [23:0] vtag, input logic resp);
        bus.req_valid_i   = rv;
        bus.hit_i         = hit;
        bus.dirty_i       = dirty;
        bus.lru_i         = lru;
        bus.address_i     = addr;
        bus.victim_tag_i  = vtag;
        bus.victim_data_i = (rv & ~hit) ? VDATA : '0;
        bus.pmem_resp_i   = resp;
        bus.pmem_rdata_i  = resp ? RDATA : '0;
    endtask

    function automatic vec_t mk(input logic rv, input logic hit, input logic dirty,
                                input logic lru, input logic resp, input logic [31:0] addr,
                                input logic [23:0] vtag, input logic stall, input logic rd,
                                input logic wr, input logic fv, input logic fway,
                                input logic [31:0] paddr, input logic [2:0] fset,
                                input logic [23:0] ftag, input logic [31:0] mc,
                                input logic [31:0] wc);
        vec_t v;
        v.rv = rv; v.hit = hit; v.dirty = dirty; v.lru = lru; v.resp = resp;
        v.addr = addr; v.vtag = vtag;
        v.stall = stall; v.rd = rd; v.wr = wr; v.fv = fv; v.fway = fway;
        v.paddr = paddr; v.fset = fset; v.ftag = ftag; v.mc = mc; v.wc = wc;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        set_in(v.rv, v.hit, v.dirty, v.lru, v.addr, v.vtag, v.resp);
        #1;
        chk32($sformatf("v%0d.stall", idx), 32'(bus.stall_o), 32'(v.stall));
        chk32($sformatf("v%0d.read", idx), 32'(bus.pmem_read_o), 32'(v.rd));
        chk32($sformatf("v%0d.write", idx), 32'(bus.pmem_write_o), 32'(v.wr));
        chk32($sformatf("v%0d.paddr", idx), bus.pmem_address_o, v.paddr);
        chk32($sformatf("v%0d.fill_valid", idx), 32'(bus.fill_valid_o), 32'(v.fv));
        chk32($sformatf("v%0d.miss_count", idx), bus.miss_count_o, v.mc);
        chk32($sformatf("v%0d.wb_count", idx), bus.wb_count_o, v.wc);
        if (v.wr)
            chk256($sformatf("v%0d.wdata", idx), bus.pmem_wdata_o, VDATA);
        if (v.fv) begin
            chk32($sformatf("v%0d.fill_way", idx), 32'(bus.fill_way_o), 32'(v.fway));
            chk32($sformatf("v%0d.fill_set", idx), 32'(bus.fill_set_o), 32'(v.fset));
            chk32($sformatf("v%0d.fill_tag", idx), 32'(bus.fill_tag_o), 32'(v.ftag));
            chk256($sformatf("v%0d.fill_data", idx), bus.fill_data_o, RDATA);
        end
        tick();
    endtask

    // Global time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tests  = 0;
        failed = 0;

        //        rv    hit   dirty lru   resp  addr          vtag          stall rd    wr    fv    fway  paddr         fset  ftag        mc     wc
        // hit and idle
        vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1240, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 24'h0,      32'd0, 32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 24'h0,      32'd0, 32'd0);
        // clean miss, lru=1, L=3
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1240, 24'h111111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 24'h0,      32'd0, 32'd0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1240, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1240,  3'd0, 24'h0,      32'd1, 32'd0);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1240, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1240,  3'd0, 24'h0,      32'd1, 32'd0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1240, 24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1240,  3'd0, 24'h0,      32'd1, 32'd0);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,          3'd2, 24'h000012, 32'd1, 32'd0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 24'h0,      32'd1, 32'd0);
        vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1240, 24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 24'h0,      32'd1, 32'd0);
        // dirty miss, victim tag ABCDEF, set 5, lru=0, Lw=2, Lr=2
        vecs[9]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_20A0, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 24'h0,      32'd1, 32'd0);
        vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hABCD_EFA0,  3'd0, 24'h0,      32'd2, 32'd0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         24'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hABCD_EFA0,  3'd0, 24'h0,      32'd2, 32'd0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_20A0,  3'd0, 24'h0,      32'd2, 32'd1);
        vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,         24'h000000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_20A0,  3'd0, 24'h0,      32'd2, 32'd1);
        vecs[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         24'h000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,          3'd5, 24'h000020, 32'd2, 32'd1);
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         24'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 24'h0,      32'd2, 32'd1);
        vecs[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         24'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,          3'd0, 24'h0,      32'd2, 32'd1);

        // reset
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b0);
        tick();
        tick();
        chk32("rst.stall", 32'(bus.stall_o), 32'd0);
        chk32("rst.read", 32'(bus.pmem_read_o), 32'd0);
        chk32("rst.write", 32'(bus.pmem_write_o), 32'd0);
        chk32("rst.paddr", bus.pmem_address_o, 32'd0);
        chk32("rst.fill_valid", 32'(bus.fill_valid_o), 32'd0);
        chk256("rst.fill_data", bus.fill_data_o, '0);
        chk32("rst.miss_count", bus.miss_count_o, 32'd0);
        chk32("rst.wb_count", bus.wb_count_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            apply(vecs[i], i);
        end

        // reset while in FILL
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3360, 24'h0, 1'b0);
        #1 chk32("rstfill.miss_stall", 32'(bus.stall_o), 32'd1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b0);
        #1 chk32("rstfill.read_before", 32'(bus.pmem_read_o), 32'd1);
        chk32("rstfill.paddr_before", bus.pmem_address_o, 32'h0000_3360);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk32("rstfill.read_after", 32'(bus.pmem_read_o), 32'd0);
        chk32("rstfill.stall_after", 32'(bus.stall_o), 32'd0);
        chk32("rstfill.miss_count", bus.miss_count_o, 32'd0);
        chk32("rstfill.wb_count", bus.wb_count_o, 32'd0);
        for (int i = 0; i < 4; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'(i % 2));
            #1;
            chk32($sformatf("rstfill.no_fill%0d", i), 32'(bus.fill_valid_o), 32'd0);
            chk32($sformatf("rstfill.idle_read%0d", i), 32'(bus.pmem_read_o), 32'd0);
            tick();
        end

        // spurious response in IDLE
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b1);
        #1 chk32("spur_idle.stall", 32'(bus.stall_o), 32'd0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b0);
        #1 chk32("spur_idle.stall_next", 32'(bus.stall_o), 32'd0);
        chk32("spur_idle.read_next", 32'(bus.pmem_read_o), 32'd0);
        chk32("spur_idle.write_next", 32'(bus.pmem_write_o), 32'd0);

        // clean miss with L=1, spurious response in INSTALL, miss ignored in REPLAY
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1240, 24'h0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b1);
        #1 chk32("spur.fill_read", 32'(bus.pmem_read_o), 32'd1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b1);
        #1 chk32("spur.install_fv", 32'(bus.fill_valid_o), 32'd1);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_7700, 24'h0, 1'b1);
        #1 chk32("spur.replay_stall", 32'(bus.stall_o), 32'd1);
        chk32("spur.replay_fv", 32'(bus.fill_valid_o), 32'd0);
        chk32("spur.replay_read", 32'(bus.pmem_read_o), 32'd0);
        tick();

        // back-to-back miss right after REPLAY
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_5580, 24'h0, 1'b0);
        #1 chk32("b2b.stall_no_gap", 32'(bus.stall_o), 32'd1);
        chk32("b2b.miss_count_before", bus.miss_count_o, 32'd1);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b1);
        #1 chk32("b2b.read", 32'(bus.pmem_read_o), 32'd1);
        chk32("b2b.paddr", bus.pmem_address_o, 32'h0000_5580);
        chk32("b2b.miss_count", bus.miss_count_o, 32'd2);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b0);
        #1 chk32("b2b.fv", 32'(bus.fill_valid_o), 32'd1);
        chk32("b2b.fill_way", 32'(bus.fill_way_o), 32'd1);
        chk32("b2b.fill_set", 32'(bus.fill_set_o), 32'd4);
        chk32("b2b.fill_tag", 32'(bus.fill_tag_o), 32'h0000_0055);
        tick();
        tick();
        chk32("b2b.idle_stall", 32'(bus.stall_o), 32'd0);

        // miss counter saturation
        force dut.u_miss_cnt.count = 32'hFFFF_FFFF;
        #1;
        release dut.u_miss_cnt.count;
        #1 chk32("sat.preset", bus.miss_count_o, 32'hFFFF_FFFF);
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1240, 24'h0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b1);
        #1 chk32("sat.hold", bus.miss_count_o, 32'hFFFF_FFFF);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 24'h0, 1'b0);
        tick();
        tick();
        chk32("sat.hold_idle", bus.miss_count_o, 32'hFFFF_FFFF);
        chk32("sat.wb_count", bus.wb_count_o, 32'd0);
        chk32("sat.idle_stall", 32'(bus.stall_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
